// File: rtl/bus_timer_irq.sv
// rtl/bus_timer_irq.sv - M6502 bus-mapped 16-bit interval timer with prescaler, auto-reload and level irq_n
module bus_timer_irq #(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter logic [7:0]  ID_VALUE  = 8'h65
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address,
  inout  wire  [7:0]  data,
  input  logic        rw,
  output logic        irq_n
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_LATCH_LO = 3'd1;
  localparam logic [2:0] REG_LATCH_HI = 3'd2;
  localparam logic [2:0] REG_COUNT_LO = 3'd3;
  localparam logic [2:0] REG_COUNT_HI = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_ID       = 3'd7;

  logic        sel;
  logic        wr_en;
  logic [2:0]  idx;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  logic        en;
  logic        auto_rl;
  logic        ie;
  logic        uf;
  logic [15:0] latch;
  logic [15:0] count;
  logic [7:0]  prescaler;
  logic [7:0]  prescale;

  logic        wr_ctrl;
  logic        wr_lo;
  logic        wr_hi;
  logic        wr_status;
  logic        wr_pre;
  logic        stop;
  logic        tick;
  logic        tick_eff;
  logic        underflow;

  assign sel   = (address[15:3] == BASE_ADDR[15:3]);
  assign idx   = address[2:0];
  assign wr_en = sel & ~rw;
  assign wdata = data;
  assign data  = (sel & rw) ? rdata : 8'hzz;

  assign wr_ctrl   = wr_en && (idx == REG_CTRL);
  assign wr_lo     = wr_en && (idx == REG_LATCH_LO);
  assign wr_hi     = wr_en && (idx == REG_LATCH_HI);
  assign wr_status = wr_en && (idx == REG_STATUS);
  assign wr_pre    = wr_en && (idx == REG_PRESCALE);

  // A CTRL write clearing EN suppresses the tick landing on the same edge.
  assign stop      = wr_ctrl && !wdata[0];
  assign tick      = en && (prescaler == prescale);
  assign tick_eff  = tick && !stop;
  assign underflow = tick_eff && (count == 16'd0);

  assign irq_n = ~(uf & ie);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
    end else if (wr_ctrl) begin
      {ie, auto_rl, en} <= wdata[2:0];
    end else if (wr_hi) begin
      en <= 1'b1;
    end else if (underflow && !auto_rl) begin
      en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch    <= 16'd0;
      prescale <= 8'd0;
    end else begin
      if (wr_lo)  latch[7:0]  <= wdata;
      if (wr_hi)  latch[15:8] <= wdata;
      if (wr_pre) prescale    <= wdata;
    end
  end

  // LATCH_HI load wins over whatever the tick would have done to count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'd0;
    end else if (wr_hi) begin
      count <= {wdata, latch[7:0]};
    end else if (tick_eff) begin
      if (count != 16'd0) begin
        count <= count - 16'd1;
      end else if (auto_rl) begin
        count <= latch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= 8'd0;
    end else if (wr_hi || !en || stop || tick) begin
      prescaler <= 8'd0;
    end else begin
      prescaler <= prescaler + 8'd1;
    end
  end

  // Setting on underflow beats a same-edge write-1 clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf <= 1'b0;
    end else if (underflow) begin
      uf <= 1'b1;
    end else if (wr_status && wdata[0]) begin
      uf <= 1'b0;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (idx)
      REG_CTRL:     rdata = {5'd0, ie, auto_rl, en};
      REG_LATCH_LO: rdata = latch[7:0];
      REG_LATCH_HI: rdata = latch[15:8];
      REG_COUNT_LO: rdata = count[7:0];
      REG_COUNT_HI: rdata = count[15:8];
      REG_STATUS:   rdata = {7'd0, uf};
      REG_PRESCALE: rdata = prescale;
      REG_ID:       rdata = ID_VALUE;
      default:      rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_bus_timer_irq.sv
// tb/tb_bus_timer_irq.sv - directed and randomized self-checking bench for bus_timer_irq
module tb_bus_timer_irq;

  localparam logic [15:0] BASE = 16'hD000;
  localparam logic [15:0] IDLE = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = IDLE;
  logic        rw = 1'b1;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dout = 8'h00;
  tri1  [7:0]  data;
  wire         irq_n;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  assign data = tb_oe ? tb_dout : 8'hzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_timer_irq #(.BASE_ADDR(BASE), .ID_VALUE(8'h65)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .address (address),
    .data    (data),
    .rw      (rw),
    .irq_n   (irq_n)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in the low clock phase; returns at the negedge after the capture edge.
  task automatic bus_wr(input logic [15:0] a, input logic [7:0] v);
    address = a; rw = 1'b0; tb_dout = v; tb_oe = 1'b1;
    @(posedge clk); #1;
    tb_oe = 1'b0; rw = 1'b1; address = IDLE;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [7:0] v);
    bus_wr(BASE + {13'd0, idx}, v);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [7:0] v, output int c);
    address = a; rw = 1'b1;
    #1;
    v = data; c = cyc;
    address = IDLE;
    @(negedge clk);
  endtask

  task automatic wait_irq(input int lim, output int c);
    while (irq_n && cyc < lim) @(negedge clk);
    c = cyc;
  endtask

  // Count seen t clocks after a load of n with prescale p, from the period rules.
  function automatic logic [15:0] model_count(input int n, input int p, input bit am, input int t);
    int per;
    int k;
    per = (n + 1) * (p + 1);
    if (am) begin
      k = (t % per) / (p + 1);
    end else begin
      k = t / (p + 1);
      if (k > n) k = n;
    end
    return 16'(n - k);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v;
    logic [15:0] mc;
    int c, e0, ev, n, p, per, ts;
    bit am;

    step(2);
    reset_n = 1'b1;
    step(1);
    chk("reset_irq_n", {15'd0, irq_n}, 16'd1);
    bus_rd(BASE + 16'd7, v, c);
    chk("reset_id", {8'h00, v}, 16'h0065);
    bus_rd(BASE, v, c);
    chk("reset_ctrl", {8'h00, v}, 16'h0000);

    // Auto-reload N=0x0100, P=0 so irq is low when reset hits mid-count.
    wr(3'd6, 8'h00); wr(3'd1, 8'h00); wr(3'd0, 8'h06); wr(3'd2, 8'h01);
    e0 = cyc;
    wait_irq(e0 + 262, c);
    chk("big_uf_time", 16'(c), 16'(e0 + 257));
    step(40);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_irq_n", {15'd0, irq_n}, 16'd1);
    for (int i = 0; i < 7; i++) begin
      bus_rd(BASE + 16'(i), v, c);
      chk("reset_reg", {8'h00, v}, 16'h0000);
    end
    bus_rd(BASE + 16'd7, v, c);
    chk("reset_id2", {8'h00, v}, 16'h0065);
    bus_rd(IDLE, v, c);
    chk("reset_hiz", {8'h00, v}, 16'h00ff);
    reset_n = 1'b1;
    step(1);

    // One-shot: P=3, N=4 underflows 20 clocks after the load edge.
    wr(3'd6, 8'h03); wr(3'd1, 8'h04); wr(3'd0, 8'h04); wr(3'd2, 8'h00);
    e0 = cyc;
    wait_irq(e0 + 25, c);
    chk("oneshot_time", 16'(c), 16'(e0 + 20));
    bus_rd(BASE + 16'd5, v, c);
    chk("oneshot_status", {8'h00, v}, 16'h0001);
    bus_rd(BASE, v, c);
    chk("oneshot_ctrl", {8'h00, v}, 16'h0004);
    step(8);
    bus_rd(BASE + 16'd3, v, c);
    chk("oneshot_cnt_lo", {8'h00, v}, 16'h0000);
    bus_rd(BASE + 16'd4, v, c);
    chk("oneshot_cnt_hi", {8'h00, v}, 16'h0000);
    wr(3'd5, 8'h01);
    chk("oneshot_clear", {15'd0, irq_n}, 16'd1);

    // Auto-reload: P=0, N=2 gives an event every 3 clocks.
    wr(3'd6, 8'h00); wr(3'd1, 8'h02); wr(3'd0, 8'h06); wr(3'd2, 8'h00);
    e0 = cyc;
    wait_irq(e0 + 8, c);
    chk("auto_first", 16'(c), 16'(e0 + 3));
    ev = e0 + 3;
    for (int i = 0; i < 3; i++) begin
      wr(3'd5, 8'h01);
      chk("auto_cleared", {15'd0, irq_n}, 16'd1);
      wait_irq(ev + 8, c);
      chk("auto_period", 16'(c), 16'(ev + 3));
      ev = ev + 3;
    end

    // Collision: clear at ev+1, then a write-1 clear landing on edge ev+3.
    wr(3'd5, 8'h01);
    step(1);
    wr(3'd5, 8'h01);
    chk("collide_irq_n", {15'd0, irq_n}, 16'd0);
    bus_rd(BASE + 16'd5, v, c);
    chk("collide_status", {8'h00, v}, 16'h0001);
    wr(3'd0, 8'h00);
    wr(3'd5, 8'h01);
    chk("stop_clear", {15'd0, irq_n}, 16'd1);

    // Decode: neighbours of the window must neither write nor drive.
    bus_wr(BASE - 16'd1, 8'hAA);
    bus_wr(BASE + 16'd8, 8'h07);
    bus_wr(BASE - 16'd2, 8'h5A);
    bus_rd(BASE, v, c);
    chk("decode_ctrl", {8'h00, v}, 16'h0000);
    bus_rd(BASE + 16'd6, v, c);
    chk("decode_prescale", {8'h00, v}, 16'h0000);
    bus_rd(BASE - 16'd1, v, c);
    chk("decode_hiz_lo", {8'h00, v}, 16'h00ff);
    bus_rd(BASE + 16'd8, v, c);
    chk("decode_hiz_hi", {8'h00, v}, 16'h00ff);
    step(5);
    chk("decode_irq_n", {15'd0, irq_n}, 16'd1);

    // IE gating: UF with IE=0 leaves irq_n high until IE is written.
    wr(3'd6, 8'h00); wr(3'd1, 8'h01); wr(3'd0, 8'h00); wr(3'd2, 8'h00);
    step(4);
    chk("ie_gate_irq_n", {15'd0, irq_n}, 16'd1);
    bus_rd(BASE + 16'd5, v, c);
    chk("ie_gate_status", {8'h00, v}, 16'h0001);
    wr(3'd0, 8'h04);
    chk("ie_enable_irq_n", {15'd0, irq_n}, 16'd0);
    wr(3'd5, 8'h01);

    // Randomized loads checked against the period arithmetic.
    for (int it = 0; it < 6; it++) begin
      n   = $urandom_range(0, 12);
      p   = $urandom_range(0, 4);
      am  = 1'($urandom_range(0, 1));
      per = (n + 1) * (p + 1);
      ts  = $urandom_range(0, per - 1);
      wr(3'd0, 8'h00);
      wr(3'd5, 8'h01);
      wr(3'd6, 8'(p));
      wr(3'd1, 8'(n));
      wr(3'd0, {5'd0, 1'b1, am, 1'b0});
      chk("rnd_idle_irq_n", {15'd0, irq_n}, 16'd1);
      wr(3'd2, 8'h00);
      e0 = cyc;
      step(ts);
      bus_rd(BASE + 16'd3, v, c);
      mc = model_count(n, p, am, c - e0);
      chk("rnd_count", {8'h00, v}, {8'h00, mc[7:0]});
      wait_irq(e0 + per + 4, c);
      chk("rnd_uf_time", 16'(c), 16'(e0 + per));
      if (am) begin
        wr(3'd5, 8'h01);
        wait_irq(e0 + 2 * per + 4, c);
        chk("rnd_reload_time", 16'(c), 16'(e0 + 2 * per));
      end else begin
        bus_rd(BASE, v, c);
        chk("rnd_oneshot_ctrl", {8'h00, v}, 16'h0004);
        bus_rd(BASE + 16'd3, v, c);
        chk("rnd_oneshot_cnt", {8'h00, v}, 16'h0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_timer_irq.md
# bus_timer_irq

Memory-mapped interval timer that responds to M6502 bus cycles and drives the CPU's `irq_n` input. It decodes an 8-byte window on the 16-bit address bus. It accepts register writes and returns register reads on the shared tri-state data bus, alongside ram64k. A 16-bit down-counter with prescaler and auto-reload raises a level interrupt on underflow, so CPU interrupt-service code can be exercised in simulation.

## Interface
Parameters:
- `BASE_ADDR`, 16'hD000, base of the 8-byte register window; low 3 bits must be 0.
- `ID_VALUE`, 8'h65, constant returned by the ID register.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `address`  input  16  CPU address bus.
- `data`  inout  8  CPU data bus; driven only during a selected read, otherwise hi-Z.
- `rw`  input  1  1 = CPU read, 0 = CPU write.
- `irq_n`  output  1  active-low interrupt request to the CPU, level.

## Operation
- Select: `sel = (address[15:3] == BASE_ADDR[15:3])`. Register index is `address[2:0]`.
- Read path is combinational: `data = (sel & rw) ? rdata : 8'hzz`.
- Writes are captured on the rising `clk` edge when `sel & ~rw`.
- Register map:
  - 0 CTRL (r/w): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable), bits7:3 read 0.
  - 1 LATCH_LO (r/w): reload value, low byte.
  - 2 LATCH_HI (r/w): reload value, high byte. A write also loads `count <= {wdata, latch_lo}`, clears the prescaler to 0 and sets EN=1.
  - 3 COUNT_LO (r): current count, low byte.
  - 4 COUNT_HI (r): current count, high byte. Writes to regs 3 and 4 are ignored.
  - 5 STATUS: bit0 UF (underflow flag). Reads are side-effect free. Writing 1 to bit0 clears UF; writing 0 has no effect.
  - 6 PRESCALE (r/w): the counter ticks once every PRESCALE+1 clocks.
  - 7 ID (r): `ID_VALUE`.
- Prescaler (8-bit):
  - Counts while EN=1.
  - `tick` is asserted in the cycle where `prescaler == PRESCALE`; the prescaler then wraps to 0.
  - When EN=0 the prescaler holds at 0.
- Counter, on `tick`:
  - If `count != 0`: `count <= count - 1`.
  - If `count == 0`: UF <= 1. If AUTO=1, `count <= latch` and EN stays 1. If AUTO=0, count stays 0 and EN <= 0 (one-shot).
- `irq_n = ~(UF & IE)`, decoded from registers with no added delay.
- Priorities within a single edge:
  - A LATCH_HI write beats the tick's decrement or reload.
  - Underflow setting UF beats a STATUS write-1 clear, so the event is not lost.
  - A CTRL write of EN=0 beats the tick's update: no decrement and no UF set.
- Reset (asynchronous, any time, including mid-count):
  - CTRL, latch, count, prescaler, PRESCALE and UF all reset to 0.
  - `irq_n` = 1; `data` = hi-Z.

## Timing
- Write-to-effect: register contents change at the capturing edge and are visible to reads immediately after it.
- Read latency: 0 cycles (combinational from `address`/`rw`).
- Load of N via LATCH_HI at edge E0 with PRESCALE=P: UF sets at edge E0 + (N+1)*(P+1). `irq_n` falls right after that edge if IE=1.
- Auto-reload period: (N+1)*(P+1) clocks between successive UF set events.
- N=0: underflow on the first tick, at E0 + (P+1).
- P=0: a tick every clock.
- Changing PRESCALE mid-count takes effect at the next comparison. If the prescaler is already above the new value, it wraps at 8'hFF before the next tick. This is acceptable and is not an error.

## Test plan
- Reset: assert `reset_n` low mid-count with N=16'h0100 loaded. Required: immediately `irq_n`=1, reads of regs 0–6 return 8'h00, reg 7 returns 8'h65, `data` is hi-Z when unselected.
- One-shot: P=3, LATCH=16'h0004, CTRL=8'h04, then write LATCH_HI. Required: UF and `irq_n`=0 exactly 20 clocks after the load edge. Afterwards EN reads 0 and count stays 0.
- Auto-reload: P=0, LATCH=16'h0002, CTRL=8'h06. Required: UF events 3 clocks apart. After each W1C clear of STATUS, `irq_n` returns to 1 and falls again 3 clocks after the previous event.
- Collision: time a STATUS write of 8'h01 onto the underflow edge. Required: UF remains 1 and `irq_n` stays 0.
- Decode: read and write at BASE_ADDR−1 and BASE_ADDR+8. Required: no register change and `data` stays hi-Z. RAM traffic is unaffected.
- IE gating: UF set with IE=0 keeps `irq_n`=1. A later write of CTRL IE=1 drives `irq_n` to 0 on the next edge.
